// File: rtl/pcileech_sysctl.sv
// System control: sequenced system/FT601 resets, debounced buttons, activity LED stretchers, tick counter.
// Optional PCIe PERST# input is enabled by defining PCILEECH_SYSCTL_PERST_EN.

module pcileech_sysctl_debounce #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);
  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // NOTE: raw asynchronous inputs pass two flops before any logic looks at them, so a metastable first stage never fans out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], din};
  end

  // Output flips only after the synchronized input has disagreed with it for CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else if (en) begin
      if (sync_q[1] != dout) begin
        if (cnt_q == CW'(CYCLES - 1)) begin
          dout  <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

module pcileech_sysctl_stretch #(
  parameter int unsigned CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic act,
  output logic led
);
  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (act)           cnt_d = CW'(CYCLES);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led   <= 1'b0;
    end else if (en) begin
      cnt_q <= cnt_d;
      led   <= (cnt_d != '0);
    end
  end
endmodule

module pcileech_sysctl #(
  parameter int unsigned RST_HOLD_CYCLES = 64,
  parameter int unsigned FT_WAIT_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned STRETCH_CYCLES  = 5000000,
  parameter int unsigned HEARTBEAT_BIT   = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_reset,
  input  logic        btn_invert,
  input  logic        act_pcie,
  input  logic        act_com,
`ifdef PCILEECH_SYSCTL_PERST_EN
  input  logic        pcie_perst_n,
`endif
  output logic        rst,
  output logic        ft601_rst_n,
  output logic        led_invert,
  output logic        led_heartbeat,
  output logic        led_pcie,
  output logic        led_com,
  output logic [63:0] tickcount
);
  typedef enum logic [1:0] {S_HOLD, S_FTWAIT, S_RUN} state_t;

  localparam int unsigned SEQ_MAX = (RST_HOLD_CYCLES > FT_WAIT_CYCLES) ? RST_HOLD_CYCLES : FT_WAIT_CYCLES;
  localparam int unsigned SW      = $clog2(SEQ_MAX + 1);

  if (RST_HOLD_CYCLES < 1 || FT_WAIT_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_cycles
    $error("pcileech_sysctl: cycle parameters must be at least 1");
  end
  if (HEARTBEAT_BIT > 63) begin : g_bad_hb
    $error("pcileech_sysctl: HEARTBEAT_BIT must select a tickcount bit");
  end

  // NOTE: rst_n asserts everything asynchronously; release is seen only through this synchronizer, so all state starts on one edge.
  logic [1:0] rsync_q;
  logic       run_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync_q <= 2'b00;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end
  assign run_en = rsync_q[1];

  logic btn_reset_db;

  pcileech_sysctl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk(clk), .rst_n(rst_n), .en(run_en), .din(btn_reset), .dout(btn_reset_db)
  );

  pcileech_sysctl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_invert (
    .clk(clk), .rst_n(rst_n), .en(run_en), .din(btn_invert), .dout(led_invert)
  );

  logic trigger;

`ifdef PCILEECH_SYSCTL_PERST_EN
  logic [1:0] perst_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perst_sync_q <= 2'b11;
    else        perst_sync_q <= {perst_sync_q[0], pcie_perst_n};
  end
  assign trigger = btn_reset_db | ~perst_sync_q[1];
`else
  assign trigger = btn_reset_db;
`endif

  state_t        state_q, state_d;
  logic [SW-1:0] seq_q, seq_d;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    if (trigger) begin
      state_d = S_HOLD;
      seq_d   = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (seq_q == SW'(RST_HOLD_CYCLES - 1)) begin
            state_d = S_FTWAIT;
            seq_d   = '0;
          end else begin
            seq_d = seq_q + SW'(1);
          end
        end
        S_FTWAIT: begin
          if (seq_q == SW'(FT_WAIT_CYCLES - 1)) begin
            state_d = S_RUN;
            seq_d   = '0;
          end else begin
            seq_d = seq_q + SW'(1);
          end
        end
        S_RUN: ;
        default: begin
          state_d = S_HOLD;
          seq_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state register.
  // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      seq_q       <= '0;
      rst         <= 1'b1;
      ft601_rst_n <= 1'b0;
    end else if (run_en) begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      rst         <= (state_d != S_RUN);
      ft601_rst_n <= (state_d != S_HOLD);
    end
  end

  // Free-running; deliberately untouched by button reset and by rst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickcount     <= 64'd0;
      led_heartbeat <= 1'b0;
    end else if (run_en) begin
      tickcount     <= tickcount + 64'd1;
      led_heartbeat <= tickcount[HEARTBEAT_BIT] ^ led_invert;
    end
  end

  pcileech_sysctl_stretch #(.CYCLES(STRETCH_CYCLES)) u_st_pcie (
    .clk(clk), .rst_n(rst_n), .en(run_en), .clr(rst), .act(act_pcie), .led(led_pcie)
  );

  pcileech_sysctl_stretch #(.CYCLES(STRETCH_CYCLES)) u_st_com (
    .clk(clk), .rst_n(rst_n), .en(run_en), .clr(rst), .act(act_com), .led(led_com)
  );
endmodule
